// File: rtl/key_schedule_gen.sv
// key_schedule_gen: iterative AES-128 key expansion, one round key per clock over a valid/ready stream.
// Optional macro KSCHED_CACHE_EN adds an 11-entry round-key cache with a combinational read port.
module key_schedule_sbox (
    input  logic [7:0] i_a,
    output logic [7:0] o_y
);
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };
    assign o_y = SBOX[i_a];
endmodule

module key_schedule_gen #(
    parameter int WORD_SIZE  = 32,
    parameter int NUM_ROUNDS = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [4*WORD_SIZE-1:0] key_in,
    input  logic                   key_valid,
    output logic                   key_ready,
    output logic [4*WORD_SIZE-1:0] rk_data,
    output logic [3:0]             rk_idx,
    output logic                   rk_valid,
    input  logic                   rk_ready,
    output logic                   busy,
`ifdef KSCHED_CACHE_EN
    input  logic [3:0]             rk_rd_idx,
    output logic [4*WORD_SIZE-1:0] rk_rd_data,
    output logic                   cache_valid,
`endif
    output logic                   done
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_EMIT = 1'b1;
    localparam int KW = 4 * WORD_SIZE;

    logic [0:0]           r_state, w_next_state;
    logic [KW-1:0]        r_key;
    logic [3:0]           r_idx;
    logic [7:0]           r_rcon, w_rcon_next;
    logic                 r_key_ready, r_done;
    logic                 w_accept, w_hs, w_last;
    logic [WORD_SIZE-1:0] w_w0, w_w1, w_w2, w_w3, w_w4, w_w5, w_w6, w_w7;
    logic [WORD_SIZE-1:0] w_rot, w_sub, w_g;

    assign {w_w0, w_w1, w_w2, w_w3} = r_key;
    assign w_rot = {w_w3[WORD_SIZE-9:0], w_w3[WORD_SIZE-1 -: 8]};

    genvar b;
    for (b = 0; b < WORD_SIZE / 8; b++) begin : g_sbox
        key_schedule_sbox u_sbox (.i_a(w_rot[8*b +: 8]), .o_y(w_sub[8*b +: 8]));
    end

    assign w_g  = w_sub ^ {r_rcon, {(WORD_SIZE-8){1'b0}}};
    assign w_w4 = w_w0 ^ w_g;
    assign w_w5 = w_w4 ^ w_w1;
    assign w_w6 = w_w5 ^ w_w2;
    assign w_w7 = w_w6 ^ w_w3;
    assign w_rcon_next = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);

    assign w_accept     = (r_state == S_IDLE) && key_valid && r_key_ready;
    assign w_hs         = (r_state == S_EMIT) && rk_ready;
    assign w_last       = r_idx == 4'(NUM_ROUNDS);
    assign w_next_state = w_accept ? S_EMIT : (w_hs && w_last) ? S_IDLE : r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_key       <= '0;
            r_idx       <= '0;
            r_rcon      <= 8'h01;
            r_key_ready <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_key_ready <= w_next_state == S_IDLE;
            r_done      <= w_hs && w_last;
            if (w_accept) begin
                r_key  <= key_in;
                r_idx  <= '0;
                r_rcon <= 8'h01;
            end else if (w_hs && !w_last) begin
                r_key  <= {w_w4, w_w5, w_w6, w_w7};
                r_rcon <= w_rcon_next;
                r_idx  <= r_idx + 4'd1;
            end
        end
    end

    assign key_ready = r_key_ready;
    assign rk_valid  = r_state == S_EMIT;
    assign busy      = r_state == S_EMIT;
    assign rk_data   = r_key;
    assign rk_idx    = r_idx;
    assign done      = r_done;

`ifdef KSCHED_CACHE_EN
    // Keys are kept for reverse-order reads during decryption.
    logic [KW-1:0] r_cache [0:NUM_ROUNDS];
    logic          r_cache_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= NUM_ROUNDS; i++) r_cache[i] <= '0;
            r_cache_valid <= 1'b0;
        end else begin
            if (w_hs) r_cache[r_idx] <= r_key;
            r_cache_valid <= w_accept ? 1'b0 : (w_hs && w_last) ? 1'b1 : r_cache_valid;
        end
    end

    assign rk_rd_data  = (rk_rd_idx <= 4'(NUM_ROUNDS)) ? r_cache[rk_rd_idx] : '0;
    assign cache_valid = r_cache_valid;
`endif
endmodule
